// File: rtl/hp0_frame_sched.sv
// rtl/hp0_frame_sched.sv - key-driven DDR frame-buffer scheduler for the HP0 sample writer
`timescale 1ns/1ps
module hp0_frame_sched #(
    parameter int unsigned FRAME_WORDS  = 1024,
    parameter int unsigned NUM_BUF      = 3,
    parameter logic [31:0] BUF_BASE     = 32'h0040_0000,
    parameter logic [31:0] BUF_STRIDE   = 32'h0010_0000,
    parameter int unsigned DEB_CYCLES   = 50000,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic        clk_25m,
    input  logic        sys_rst_n,
    input  logic        key_start,
    input  logic        key_stop,
    input  logic        src_valid,
    input  logic        wr_busy,
    output logic        sched_data_en,
    output logic        sched_data_rst_n,
    output logic [31:0] sched_base_addr,
    output logic [1:0]  buf_idx,
    output logic        frame_done,
    output logic        overflow,
    output logic [1:0]  state
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [1:0]         key_raw;
    logic [1:0]         sync1_q, sync2_q, deb_q, press_q;
    logic [1:0][DW-1:0] deb_cnt_q;

    logic [WW-1:0] word_cnt_q;
    logic [1:0]    arm_cnt_q;
    logic [FW-1:0] flush_cnt_q;
    logic [1:0]    buf_idx_q;
    logic [31:0]   base_q;
    logic          frame_done_q, overflow_q, stop_req_q;

    logic start_p, stop_p, stop_eff;
    logic accept, last_word, arm_done, flush_done, enter_arm;
    logic [1:0] buf_inc, arm_idx;

    function automatic logic [31:0] base_for(input logic [1:0] idx);
        return BUF_BASE + BUF_STRIDE * {30'd0, idx};
    endfunction

    assign key_raw = {key_stop, key_start};

    // Debounced level only follows the synchronised key after DEB_CYCLES identical samples
    always_ff @(posedge clk_25m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            deb_q     <= 2'b11;
            press_q   <= 2'b00;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                press_q[k] <= 1'b0;
                if (sync2_q[k] == deb_q[k]) begin
                    deb_cnt_q[k] <= '0;
                end else if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
                    deb_q[k]     <= sync2_q[k];
                    deb_cnt_q[k] <= '0;
                    press_q[k]   <= ~sync2_q[k];
                end else begin
                    deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    assign start_p    = press_q[0];
    assign stop_p     = press_q[1];
    assign stop_eff   = stop_req_q | stop_p;
    assign accept     = sched_data_en;
    assign last_word  = accept && (word_cnt_q == WW'(FRAME_WORDS - 1));
    assign arm_done   = (arm_cnt_q == 2'd3);
    assign flush_done = (flush_cnt_q == FW'(FLUSH_CYCLES - 1));
    assign enter_arm  = (state_d == S_ARM) && (state_q != S_ARM);
    assign buf_inc    = (buf_idx_q == 2'(NUM_BUF - 1)) ? 2'd0 : buf_idx_q + 2'd1;
    assign arm_idx    = (state_q == S_IDLE) ? 2'd0 : buf_idx_q;

    always_ff @(posedge clk_25m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_p && !stop_p) state_d = S_ARM;
            S_ARM:   if (stop_p) state_d = S_IDLE;
                     else if (arm_done) state_d = S_RUN;
            S_RUN:   if (last_word) state_d = S_FLUSH;
            S_FLUSH: if (flush_done) state_d = stop_eff ? S_IDLE : S_ARM;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sched_data_en    = 1'b0;
        sched_data_rst_n = 1'b0;
        case (state_q)
            S_RUN: begin
                sched_data_en    = src_valid & ~wr_busy;
                sched_data_rst_n = 1'b1;
            end
            S_FLUSH: sched_data_rst_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_25m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_cnt_q   <= '0;
            arm_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            buf_idx_q    <= '0;
            base_q       <= BUF_BASE;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            stop_req_q   <= 1'b0;
        end else begin
            frame_done_q <= last_word;

            if (state_q == S_IDLE && state_d == S_ARM) begin
                buf_idx_q  <= 2'd0;
                overflow_q <= 1'b0;
            end else if (last_word) begin
                buf_idx_q <= buf_inc;
            end
            if (state_q == S_RUN && src_valid && wr_busy) begin
                overflow_q <= 1'b1;
            end

            if (enter_arm) begin
                base_q     <= base_for(arm_idx);
                word_cnt_q <= '0;
                arm_cnt_q  <= '0;
            end else begin
                if (state_q == S_ARM) arm_cnt_q <= arm_cnt_q + 2'd1;
                if (accept) word_cnt_q <= word_cnt_q + WW'(1);
            end

            if (state_q == S_FLUSH) begin
                flush_cnt_q <= flush_done ? '0 : flush_cnt_q + FW'(1);
            end else begin
                flush_cnt_q <= '0;
            end

            // A stop seen during RUN/FLUSH waits for the frame; leaving to IDLE consumes it
            if ((state_q == S_RUN || state_q == S_FLUSH) && stop_p) stop_req_q <= 1'b1;
            if ((state_q == S_FLUSH && flush_done && stop_eff) || (state_q == S_ARM && stop_p)) begin
                stop_req_q <= 1'b0;
            end
        end
    end

    assign sched_base_addr = base_q;
    assign buf_idx         = buf_idx_q;
    assign frame_done      = frame_done_q;
    assign overflow        = overflow_q;
    assign state           = state_q;

endmodule

// File: tb/tb_hp0_frame_sched.sv
// tb/tb_hp0_frame_sched.sv - directed bench for hp0_frame_sched
`timescale 1ns/1ps
module tb_hp0_frame_sched;

    logic        clk_25m   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_start = 1'b1;
    logic        key_stop  = 1'b1;
    logic        src_valid = 1'b0;
    logic        wr_busy   = 1'b0;
    logic        sched_data_en, sched_data_rst_n, frame_done, overflow;
    logic [31:0] sched_base_addr;
    logic [1:0]  buf_idx, state;

    int n_chk  = 0;
    int n_fail = 0;

    hp0_frame_sched #(
        .FRAME_WORDS (8),
        .NUM_BUF     (3),
        .BUF_BASE    (32'h0040_0000),
        .BUF_STRIDE  (32'h0000_0100),
        .DEB_CYCLES  (4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk_25m         (clk_25m),
        .sys_rst_n       (sys_rst_n),
        .key_start       (key_start),
        .key_stop        (key_stop),
        .src_valid       (src_valid),
        .wr_busy         (wr_busy),
        .sched_data_en   (sched_data_en),
        .sched_data_rst_n(sched_data_rst_n),
        .sched_base_addr (sched_base_addr),
        .buf_idx         (buf_idx),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .state           (state)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic hold_keys(input bit st, input bit sp, input int n);
        @(posedge clk_25m); #1;
        key_start = ~st;
        key_stop  = ~sp;
        repeat (n) @(posedge clk_25m);
        #1;
        key_start = 1'b1;
        key_stop  = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int bound, input string tag);
        int i;
        i = 0;
        while (state !== s && i < bound) begin
            @(negedge clk_25m);
            i++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic arm_check(input logic [31:0] base, input logic [1:0] idx, input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        wait_state(2'd1, 40, $sformatf("%s_enter_arm", tag));
        chk($sformatf("%s_base", tag), sched_base_addr, base);
        chk($sformatf("%s_idx", tag), 32'(buf_idx), 32'(idx));
        while (state == 2'd1 && n < 20) begin
            if (sched_data_rst_n !== 1'b0 || sched_data_en !== 1'b0) bad++;
            n++;
            @(negedge clk_25m);
        end
        chk($sformatf("%s_arm_len", tag), n, 4);
        chk($sformatf("%s_arm_rst", tag), bad, 0);
        chk($sformatf("%s_run", tag), 32'(state), 32'd2);
    endtask

    task automatic run_frame(input int exp_acc, input logic [1:0] exp_idx, input logic [1:0] exp_after,
                             input int busy_from, input int busy_len, input string tag);
        int acc, drop, busy_en, c, fl, fl_bad;
        acc = 0; drop = 0; busy_en = 0; c = 0; fl = 0; fl_bad = 0;
        while (frame_done !== 1'b1 && c < 100) begin
            if (sched_data_en === 1'b1) acc++;
            if (state == 2'd2 && src_valid && wr_busy) begin
                drop++;
                if (sched_data_en !== 1'b0) busy_en++;
            end
            @(posedge clk_25m); #1;
            c++;
            wr_busy = (c >= busy_from) && (c < busy_from + busy_len);
            @(negedge clk_25m);
        end
        chk($sformatf("%s_accepts", tag), acc, exp_acc);
        chk($sformatf("%s_done_state", tag), 32'(state), 32'd3);
        chk($sformatf("%s_next_idx", tag), 32'(buf_idx), 32'(exp_idx));
        chk($sformatf("%s_busy_en", tag), busy_en, 0);
        if (busy_len > 0) chk($sformatf("%s_drops", tag), drop, busy_len);
        while (state == 2'd3 && fl < 20) begin
            if (sched_data_en !== 1'b0 || sched_data_rst_n !== 1'b1) fl_bad++;
            if (fl > 0 && frame_done !== 1'b0) fl_bad++;
            fl++;
            @(negedge clk_25m);
        end
        chk($sformatf("%s_flush_len", tag), fl, 2);
        chk($sformatf("%s_flush_out", tag), fl_bad, 0);
        chk($sformatf("%s_after", tag), 32'(state), 32'(exp_after));
    endtask

    task automatic reset_outputs(input string tag);
        chk($sformatf("%s_state", tag), 32'(state), 32'd0);
        chk($sformatf("%s_en", tag), 32'(sched_data_en), 32'd0);
        chk($sformatf("%s_rstn", tag), 32'(sched_data_rst_n), 32'd0);
        chk($sformatf("%s_base", tag), sched_base_addr, 32'h0040_0000);
        chk($sformatf("%s_idx", tag), 32'(buf_idx), 32'd0);
        chk($sformatf("%s_done", tag), 32'(frame_done), 32'd0);
        chk($sformatf("%s_ovf", tag), 32'(overflow), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bases [3];
        logic [1:0]  idxs  [3];
        logic [1:0]  nxts  [3];
        int n, g, bad, fd;
        bases = '{32'h0040_0100, 32'h0040_0200, 32'h0040_0000};
        idxs  = '{2'd1, 2'd2, 2'd0};
        nxts  = '{2'd2, 2'd0, 2'd1};

        repeat (3) @(negedge clk_25m);
        reset_outputs("por");
        @(posedge clk_25m); #1;
        sys_rst_n = 1'b1;
        src_valid = 1'b1;

        hold_keys(1'b1, 1'b0, 3);
        bad = 0;
        repeat (12) begin
            @(negedge clk_25m);
            if (state !== 2'd0) bad++;
        end
        chk("short_press", bad, 0);

        fork hold_keys(1'b1, 1'b0, 10); join_none
        arm_check(32'h0040_0000, 2'd0, "f0");
        run_frame(8, 2'd1, 2'd1, 0, 0, "f0");

        for (int i = 0; i < 3; i++) begin
            arm_check(bases[i], idxs[i], $sformatf("bb%0d", i));
            run_frame(8, nxts[i], 2'd1, 0, 0, $sformatf("bb%0d", i));
        end

        arm_check(32'h0040_0100, 2'd1, "ovf");
        run_frame(8, 2'd2, 2'd1, 2, 2, "ovf");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        arm_check(32'h0040_0200, 2'd2, "stop");
        n = 0;
        g = 0;
        while (n < 3 && g < 50) begin
            if (sched_data_en === 1'b1) n++;
            if (n == 3) break;
            @(negedge clk_25m);
            g++;
        end
        @(posedge clk_25m); #1;
        src_valid = 1'b0;
        fork hold_keys(1'b0, 1'b1, 10); join_none
        bad = 0;
        repeat (16) begin
            @(negedge clk_25m);
            if (state !== 2'd2 || sched_data_en !== 1'b0) bad++;
        end
        chk("stop_holds_run", bad, 0);
        @(posedge clk_25m); #1;
        src_valid = 1'b1;
        @(negedge clk_25m);
        run_frame(5, 2'd0, 2'd0, 0, 0, "stop");
        chk("idle_ovf_kept", 32'(overflow), 32'd1);

        hold_keys(1'b1, 1'b1, 10);
        bad = 0;
        repeat (10) begin
            @(negedge clk_25m);
            if (state !== 2'd0) bad++;
        end
        chk("both_keys_idle", bad, 0);
        chk("both_keys_ovf", 32'(overflow), 32'd1);

        fork hold_keys(1'b1, 1'b0, 10); join_none
        arm_check(32'h0040_0000, 2'd0, "restart");
        chk("restart_ovf_clr", 32'(overflow), 32'd0);
        n = 0;
        g = 0;
        while (n < 5 && g < 50) begin
            if (sched_data_en === 1'b1) n++;
            if (n == 5) break;
            @(negedge clk_25m);
            g++;
        end
        @(posedge clk_25m); #1;
        sys_rst_n = 1'b0;
        @(negedge clk_25m);
        reset_outputs("midrst");
        repeat (2) @(posedge clk_25m);
        #1;
        sys_rst_n = 1'b1;
        bad = 0;
        fd = 0;
        repeat (20) begin
            @(negedge clk_25m);
            if (state !== 2'd0) bad++;
            if (frame_done !== 1'b0) fd++;
        end
        chk("midrst_idle", bad, 0);
        chk("midrst_no_done", fd, 0);

        fork hold_keys(1'b1, 1'b0, 10); join_none
        arm_check(32'h0040_0000, 2'd0, "post");
        run_frame(8, 2'd1, 2'd1, 0, 0, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
